// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - framebuffer geometry, data types and write-arbiter state encoding
package fb_pkg;
   localparam int unsigned H_RES     = 640;
   localparam int unsigned V_RES     = 480;
   localparam int unsigned FB_PIXELS = H_RES * V_RES;
   localparam int unsigned ADDR_W    = 19;
   localparam int unsigned COLOR_W   = 24;
   localparam int unsigned X_W       = 10;
   localparam int unsigned Y_W       = 9;

   typedef logic [COLOR_W-1:0] pixel_t;
   typedef logic [ADDR_W-1:0]  fb_addr_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } fb_state_e;
endpackage

// File: rtl/fb_xy_to_addr.sv
// rtl/fb_xy_to_addr.sv - combinational (x,y) to linear framebuffer address
// Optional FB_CLIP_EN adds an in-range flag for the clipping path.
module fb_xy_to_addr
   import fb_pkg::*;
`ifdef FB_CLIP_EN
#(
   parameter int unsigned V_ROWS = V_RES
)
`endif
(
   input  logic [X_W-1:0] i_x,
   input  logic [Y_W-1:0] i_y,
   output fb_addr_t       o_addr
`ifdef FB_CLIP_EN
   ,
   output logic           o_in_range
`endif
);
   fb_addr_t w_y;

   // y*640 as (y<<9)+(y<<7); worst case 511*640+1023 still fits ADDR_W
   assign w_y    = fb_addr_t'(i_y);
   assign o_addr = (w_y << 9) + (w_y << 7) + fb_addr_t'(i_x);

`ifdef FB_CLIP_EN
   assign o_in_range = (32'(i_x) < H_RES) && (32'(i_y) < V_ROWS);
`endif
endmodule

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin pixel/clear arbiter owning the framebuffer write port
// Optional FB_CLIP_EN drops out-of-range pixels and exposes clip_cnt.
module fb_write_arbiter
   import fb_pkg::*;
#(
   parameter int unsigned V_ROWS = V_RES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear_start,
   input  pixel_t             clear_color,
   output logic               clear_busy,
   input  logic               p0_valid,
   output logic               p0_ready,
   input  logic [X_W-1:0]     p0_x,
   input  logic [Y_W-1:0]     p0_y,
   input  pixel_t             p0_color,
   input  logic               p1_valid,
   output logic               p1_ready,
   input  logic [X_W-1:0]     p1_x,
   input  logic [Y_W-1:0]     p1_y,
   input  pixel_t             p1_color,
   output logic               fb_we,
   output fb_addr_t           fb_waddr,
   output pixel_t             fb_wdata
`ifdef FB_CLIP_EN
   ,
   output logic [15:0]        clip_cnt
`endif
);
   localparam fb_addr_t CLR_LAST = fb_addr_t'(H_RES * V_ROWS - 1);

   fb_state_e      r_state;
   logic           r_last_grant;
   logic           r_we;
   logic           r_busy;
   fb_addr_t       r_waddr;
   pixel_t         r_wdata;
   fb_addr_t       r_clr_cnt;
   pixel_t         r_clr_color;

   logic           w_gnt0;
   logic           w_gnt1;
   logic [X_W-1:0] w_x;
   logic [Y_W-1:0] w_y;
   pixel_t         w_color;
   fb_addr_t       w_addr;
   logic           w_pix_ok;

   // r_last_grant=1 means lane 1 was served last, so lane 0 wins the first tie after reset
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (rst_n && r_state == IDLE && !clear_start) begin
         if (p0_valid && p1_valid) begin
            w_gnt0 = r_last_grant;
            w_gnt1 = !r_last_grant;
         end else begin
            w_gnt0 = p0_valid;
            w_gnt1 = p1_valid;
         end
      end
   end

   assign p0_ready = w_gnt0;
   assign p1_ready = w_gnt1;

   assign w_x     = w_gnt1 ? p1_x     : p0_x;
   assign w_y     = w_gnt1 ? p1_y     : p0_y;
   assign w_color = w_gnt1 ? p1_color : p0_color;

   fb_xy_to_addr
`ifdef FB_CLIP_EN
      #(.V_ROWS(V_ROWS))
`endif
      u_xy_to_addr (
         .i_x        (w_x),
         .i_y        (w_y),
         .o_addr     (w_addr)
`ifdef FB_CLIP_EN
         ,
         .o_in_range (w_pix_ok)
`endif
      );

`ifndef FB_CLIP_EN
   assign w_pix_ok = 1'b1;
`else
   logic [15:0] r_clip_cnt;
   assign clip_cnt = r_clip_cnt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_we         <= 1'b0;
         r_busy       <= 1'b0;
         r_waddr      <= '0;
         r_wdata      <= '0;
         r_clr_cnt    <= '0;
         r_clr_color  <= '0;
`ifdef FB_CLIP_EN
         r_clip_cnt   <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (clear_start) begin
                  r_clr_color <= clear_color;
                  r_clr_cnt   <= '0;
                  r_state     <= CLEAR;
                  r_busy      <= 1'b1;
                  r_we        <= 1'b0;
               end else if (w_gnt0 || w_gnt1) begin
                  r_last_grant <= w_gnt1;
                  r_we         <= w_pix_ok;
                  if (w_pix_ok) begin
                     r_waddr <= w_addr;
                     r_wdata <= w_color;
                  end
`ifdef FB_CLIP_EN
                  else if (r_clip_cnt != 16'hFFFF) begin
                     r_clip_cnt <= r_clip_cnt + 16'd1;
                  end
`endif
               end else begin
                  r_we <= 1'b0;
               end
            end
            CLEAR: begin
               r_we      <= 1'b1;
               r_waddr   <= r_clr_cnt;
               r_wdata   <= r_clr_color;
               r_clr_cnt <= r_clr_cnt + fb_addr_t'(1);
               // busy tracks the next state, so it falls as the final clear write issues
               if (r_clr_cnt == CLR_LAST) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign fb_we      = r_we;
   assign fb_waddr   = r_waddr;
   assign fb_wdata   = r_wdata;
   assign clear_busy = r_busy;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - directed plus randomized self-checking bench for fb_write_arbiter
module tb_fb_write_arbiter;
   import fb_pkg::*;

   localparam int ROWS = 4;
   localparam int NCLR = 640 * ROWS;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           clear_start;
   pixel_t         clear_color;
   logic           clear_busy;
   logic           p0_valid, p1_valid;
   logic           p0_ready, p1_ready;
   logic [9:0]     p0_x, p1_x;
   logic [8:0]     p0_y, p1_y;
   pixel_t         p0_color, p1_color;
   logic           fb_we;
   fb_addr_t       fb_waddr;
   pixel_t         fb_wdata;
`ifdef FB_CLIP_EN
   logic [15:0]    clip_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   int m_last;
   int m_we;
   int m_addr;
   int m_data;

   always #5 clk = ~clk;

   fb_write_arbiter #(.V_ROWS(ROWS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_start (clear_start),
      .clear_color (clear_color),
      .clear_busy  (clear_busy),
      .p0_valid    (p0_valid),
      .p0_ready    (p0_ready),
      .p0_x        (p0_x),
      .p0_y        (p0_y),
      .p0_color    (p0_color),
      .p1_valid    (p1_valid),
      .p1_ready    (p1_ready),
      .p1_x        (p1_x),
      .p1_y        (p1_y),
      .p1_color    (p1_color),
      .fb_we       (fb_we),
      .fb_waddr    (fb_waddr),
      .fb_wdata    (fb_wdata)
`ifdef FB_CLIP_EN
      ,
      .clip_cnt    (clip_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_px(input int lane, input logic v, input int x, input int y, input int c);
      if (lane == 0) begin
         p0_valid = v; p0_x = 10'(x); p0_y = 9'(y); p0_color = 24'(c);
      end else begin
         p1_valid = v; p1_x = 10'(x); p1_y = 9'(y); p1_color = 24'(c);
      end
   endtask

   // Reference: outputs reflect last cycle's accepted pixel; ties go to the lane not served last.
   task automatic model_step(input string tag);
      int lane;
      @(negedge clk);
      chk({tag, ".fb_we"},    32'(fb_we),    32'(m_we));
      chk({tag, ".fb_waddr"}, 32'(fb_waddr), 32'(m_addr));
      chk({tag, ".fb_wdata"}, 32'(fb_wdata), 32'(m_data));
      lane = -1;
      if (p0_valid && p1_valid) lane = 1 - m_last;
      else if (p0_valid)        lane = 0;
      else if (p1_valid)        lane = 1;
      chk({tag, ".p0_ready"}, 32'(p0_ready), 32'(lane == 0));
      chk({tag, ".p1_ready"}, 32'(p1_ready), 32'(lane == 1));
      if (lane == 0) begin
         m_last = 0; m_we = 1; m_addr = int'(p0_y) * 640 + int'(p0_x); m_data = int'(p0_color);
      end else if (lane == 1) begin
         m_last = 1; m_we = 1; m_addr = int'(p1_y) * 640 + int'(p1_x); m_data = int'(p1_color);
      end else begin
         m_we = 0;
      end
      tick();
   endtask

   task automatic model_reset();
      m_last = 1; m_we = 0; m_addr = 0; m_data = 0;
   endtask

   initial begin
      int busy_cycles;
      int found;
      rst_n = 1'b0;
      clear_start = 1'b0;
      clear_color = '0;
      set_px(0, 1'b0, 0, 0, 0);
      set_px(1, 1'b0, 0, 0, 0);
      model_reset();
      repeat (3) tick();
      rst_n = 1'b1;

      @(negedge clk);
      chk("reset.fb_we", 32'(fb_we), 0);
      chk("reset.fb_waddr", 32'(fb_waddr), 0);
      chk("reset.fb_wdata", 32'(fb_wdata), 0);
      chk("reset.clear_busy", 32'(clear_busy), 0);
      chk("reset.p0_ready", 32'(p0_ready), 0);
      chk("reset.p1_ready", 32'(p1_ready), 0);
      tick();

      // both lanes valid from reset: p0,p1,p0,p1 with back-to-back writes
      set_px(0, 1'b1, 10, 1, 24'h0000AA);
      set_px(1, 1'b1, 20, 2, 24'h0000BB);
      for (int i = 0; i < 4; i++) begin
         chk("rr.p0_first", 32'(i % 2 == 0), 32'(m_last == 1));
         model_step("rr");
      end
      set_px(0, 1'b0, 0, 0, 0);
      set_px(1, 1'b0, 0, 0, 0);
      model_step("rr_tail");

      set_px(0, 1'b1, 3, 2, 24'hFF0000);
      model_step("single");
      set_px(0, 1'b0, 0, 0, 0);
      @(negedge clk);
      chk("single.waddr_1283", 32'(fb_waddr), 1283);
      chk("single.wdata", 32'(fb_wdata), 32'hFF0000);
      chk("single.we", 32'(fb_we), 1);
      m_we = 0;
      tick();

      set_px(1, 1'b1, 639, 479, 24'h00FF00);
      model_step("corner");
      set_px(1, 1'b0, 0, 0, 0);
      @(negedge clk);
      chk("corner.waddr_307199", 32'(fb_waddr), 307199);
      m_we = 0;
      tick();

      for (int i = 0; i < 300; i++) begin
         set_px(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 639)),
                int'($urandom_range(0, 479)), int'($urandom & 32'hFFFFFF));
         set_px(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 639)),
                int'($urandom_range(0, 479)), int'($urandom & 32'hFFFFFF));
         model_step("rand");
      end
      set_px(0, 1'b0, 0, 0, 0);
      set_px(1, 1'b0, 0, 0, 0);
      model_step("rand_tail");

      // clear with p0 held valid throughout; a second clear_start mid-clear is ignored
      clear_start = 1'b1;
      clear_color = 24'h123456;
      set_px(0, 1'b1, 5, 3, 24'hABCDEF);
      @(negedge clk);
      chk("clr.start.p0_ready", 32'(p0_ready), 0);
      chk("clr.start.busy", 32'(clear_busy), 0);
      tick();
      clear_start = 1'b0;
      @(negedge clk);
      chk("clr.enter.busy", 32'(clear_busy), 1);
      chk("clr.enter.we", 32'(fb_we), 0);
      chk("clr.enter.p0_ready", 32'(p0_ready), 0);
      busy_cycles = clear_busy ? 1 : 0;
      tick();
      for (int k = 0; k < NCLR; k++) begin
         if (k == 100) begin clear_start = 1'b1; clear_color = 24'h777777; end
         if (k == 101) clear_start = 1'b0;
         @(negedge clk);
         chk("clr.we", 32'(fb_we), 1);
         chk("clr.waddr", 32'(fb_waddr), 32'(k));
         chk("clr.wdata", 32'(fb_wdata), 32'h123456);
         chk("clr.p0_ready", 32'(p0_ready), 32'(k == NCLR - 1));
         chk("clr.p1_ready", 32'(p1_ready), 0);
         chk("clr.busy", 32'(clear_busy), 32'(k != NCLR - 1));
         if (clear_busy) busy_cycles++;
         tick();
      end
      set_px(0, 1'b0, 0, 0, 0);
      @(negedge clk);
      chk("clr.busy_cycles", 32'(busy_cycles), 32'(NCLR));
      chk("clr.after.we", 32'(fb_we), 1);
      chk("clr.after.waddr", 32'(fb_waddr), 3 * 640 + 5);
      chk("clr.after.wdata", 32'(fb_wdata), 32'hABCDEF);
      chk("clr.after.busy", 32'(clear_busy), 0);
      tick();
      m_last = 0; m_we = 0; m_addr = 3 * 640 + 5; m_data = 32'hABCDEF;
      model_step("post_clr");

      // reset asserted while the clear is writing address 1000
      clear_start = 1'b1;
      clear_color = 24'h5A5A5A;
      tick();
      clear_start = 1'b0;
      set_px(0, 1'b1, 7, 7, 24'h010203);
      set_px(1, 1'b1, 8, 8, 24'h040506);
      found = 0;
      for (int i = 0; i < 1100 && found == 0; i++) begin
         @(negedge clk);
         if (fb_we && fb_waddr == 19'd1000) found = 1;
         else tick();
      end
      chk("abort.reached_1000", 32'(found), 1);
      rst_n = 1'b0;
      #1;
      chk("abort.we", 32'(fb_we), 0);
      chk("abort.busy", 32'(clear_busy), 0);
      chk("abort.waddr", 32'(fb_waddr), 0);
      chk("abort.wdata", 32'(fb_wdata), 0);
      chk("abort.p0_ready", 32'(p0_ready), 0);
      chk("abort.p1_ready", 32'(p1_ready), 0);
      tick();
      tick();
      #2;
      rst_n = 1'b1;
      model_reset();
      model_step("abort.resume");
      chk("abort.p0_won", 32'(m_last), 0);
      model_step("abort.resume2");
      set_px(0, 1'b0, 0, 0, 0);
      set_px(1, 1'b0, 0, 0, 0);
      model_step("abort.tail");

`ifdef FB_CLIP_EN
      set_px(0, 1'b1, 640, 0, 24'hDEAD00);
      @(negedge clk);
      chk("clip.p0_ready", 32'(p0_ready), 1);
      tick();
      set_px(0, 1'b0, 0, 0, 0);
      @(negedge clk);
      chk("clip.we", 32'(fb_we), 0);
      chk("clip.cnt", 32'(clip_cnt), 1);
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
